// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Program-counter and fetch-queue stage placed just upstream of
// InstructionFetch. The PC register drives fetch_addr, the instruction that
// comes back in the same cycle is captured together with its PC into a
// 2-entry circular queue, and the queue head is offered to decode over a
// valid/ready handshake.
//
// Sequential fetch advances the PC by PC_STEP bytes. halt (level) stops
// fetching while the queue keeps draining. redirect_valid loads a new PC
// and flushes the queue.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            asynchronous, active-high reset
//   fetch_addr     address to InstructionFetch (the PC register)
//   fetch_instr    instruction for fetch_addr, returned the same cycle
//   redirect_valid load redirect_pc and flush the queue
//   redirect_pc    redirect target
//   halt           suppress fetch/enqueue while high
//   dec_valid      queue head valid
//   dec_ready      decode accepts the head
//   dec_instr      head instruction
//   dec_pc         PC of the head instruction
//   q_count        queue occupancy, 0..2
// ---------------------------------------------------------------------------
module fetch_sequencer #(
  parameter int                ADDR_W   = 72,
  parameter int                INSTR_W  = 72,
  parameter int                PC_STEP  = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  fetch_addr,
  input  logic [INSTR_W-1:0] fetch_instr,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  output logic [1:0]         q_count
);

  // PC increment sized to the address width so the add wraps naturally.
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  logic [ADDR_W-1:0]  pc_reg;
  logic [ADDR_W-1:0]  ent_pc    [2];
  logic [INSTR_W-1:0] ent_instr [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         count;

  logic deq;
  logic full;
  logic enq;

  // The head is presented straight from the storage slot under the read
  // pointer, so the dec_* outputs cannot change while decode stalls: only
  // a dequeue moves rd_ptr, and the write pointer never targets the head
  // slot while it is still occupied.
  always_comb begin
    dec_valid  = (count != 2'd0);
    dec_instr  = ent_instr[rd_ptr];
    dec_pc     = ent_pc[rd_ptr];
    fetch_addr = pc_reg;
    q_count    = count;
  end

  // Handshake and enqueue decision. When the queue is full, a dequeue in
  // the same cycle frees the slot the new instruction goes into, which is
  // what lets a ready decoder sustain one instruction per cycle. Redirect
  // beats halt, and both suppress the enqueue.
  always_comb begin
    deq  = dec_valid & dec_ready;
    full = (count == 2'd2);
    enq  = ~redirect_valid & ~halt & (~full | deq);
  end

  // PC, pointers, occupancy and queue storage. A redirect discards the
  // queue by resetting pointers and count; a head taken by decode in that
  // same cycle still counts as delivered, and decode drops it itself. When
  // full with no dequeue the PC simply holds, so the same address is
  // fetched again next cycle rather than being lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg       <= RESET_PC;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      ent_pc[0]    <= '0;
      ent_pc[1]    <= '0;
      ent_instr[0] <= '0;
      ent_instr[1] <= '0;
    end else if (redirect_valid) begin
      pc_reg <= redirect_pc;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (enq) begin
        ent_pc[wr_ptr]    <= pc_reg;
        ent_instr[wr_ptr] <= fetch_instr;
        wr_ptr            <= ~wr_ptr;
        pc_reg            <= pc_reg + STEP;
      end
      if (deq) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Drives fetch_sequencer with directed scenarios followed by a randomized
// run. The reference model is a plain queue of {pc, instr} records plus a
// model PC; instruction memory is a pure function of the address.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

  logic         clk;
  logic         rst;
  logic [71:0]  fetch_addr;
  logic [71:0]  fetch_instr;
  logic         redirect_valid;
  logic [71:0]  redirect_pc;
  logic         halt;
  logic         dec_valid;
  logic         dec_ready;
  logic [71:0]  dec_instr;
  logic [71:0]  dec_pc;
  logic [1:0]   q_count;

  int passCount;
  int checkCount;

  logic [143:0] mq[$];
  logic [71:0]  mpc;

  fetch_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_addr     (fetch_addr),
    .fetch_instr    (fetch_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .q_count        (q_count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: a fixed scramble of the address.
  function automatic logic [71:0] instrOf(input logic [71:0] a);
    return {a[35:0], ~a[71:36]} ^ 72'hA5_3C96_0F5A_C3E1_7B2D;
  endfunction

  assign fetch_instr = instrOf(fetch_addr);

  // One comparison, counted and reported on failure.
  task automatic checkOutput(input string tag, input logic [143:0] obs,
                             input logic [143:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Compare every visible output against the model.
  task automatic compareModel(input string tag);
    checkOutput({tag, "_valid"}, 144'(dec_valid), 144'(mq.size() != 0));
    checkOutput({tag, "_count"}, 144'(q_count), 144'(mq.size()));
    checkOutput({tag, "_faddr"}, 144'(fetch_addr), 144'(mpc));
    if (mq.size() != 0) begin
      checkOutput({tag, "_pc"}, 144'(dec_pc), 144'(mq[0][143:72]));
      checkOutput({tag, "_instr"}, 144'(dec_instr), 144'(mq[0][71:0]));
    end
  endtask

  // Drive one cycle of inputs (called at edge+1), advance the model by the
  // rules of one edge, then sample at the next edge+1.
  task automatic applyStimulus(input logic rv, input logic [71:0] rpc,
                               input logic h, input logic rdy,
                               input string tag);
    logic deq;
    logic enq;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = h;
    dec_ready      = rdy;
    deq = (mq.size() != 0) && rdy;
    if (rv) begin
      mq.delete();
      mpc = rpc;
    end else begin
      enq = !h && (mq.size() < 2 || deq);
      if (deq) void'(mq.pop_front());
      if (enq) begin
        mq.push_back({mpc, instrOf(mpc)});
        mpc = mpc + 72'd9;
      end
    end
    @(posedge clk);
    #1;
    compareModel(tag);
  endtask

  // Asynchronous reset pulse asserted between edges; outputs must clear
  // before any clock edge arrives.
  task automatic pulseReset(input string tag);
    rst = 1'b1;
    #2;
    checkOutput({tag, "_rst_valid"}, 144'(dec_valid), 144'(0));
    checkOutput({tag, "_rst_count"}, 144'(q_count), 144'(0));
    checkOutput({tag, "_rst_faddr"}, 144'(fetch_addr), 144'(0));
    checkOutput({tag, "_rst_pc"}, 144'(dec_pc), 144'(0));
    checkOutput({tag, "_rst_instr"}, 144'(dec_instr), 144'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    mpc = 72'd0;
  endtask

  initial begin
    logic [71:0] expPc [4];
    logic [95:0] rnd;
    logic [71:0] held;
    passCount      = 0;
    checkCount     = 0;
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    dec_ready      = 1'b1;
    mpc            = 72'd0;
    expPc[0] = 72'h0;
    expPc[1] = 72'h9;
    expPc[2] = 72'h12;
    expPc[3] = 72'h1B;

    // Scenario 1: reset, then free-running fetch with decode always ready.
    #2;
    checkOutput("t1_reset_faddr", 144'(fetch_addr), 144'(0));
    checkOutput("t1_reset_valid", 144'(dec_valid), 144'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    compareModel("t1_release");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, "t1_run");
      checkOutput("t1_seq_pc", 144'(dec_pc), 144'(expPc[i]));
      checkOutput("t1_seq_valid", 144'(dec_valid), 144'(1));
    end

    // Scenario 2: decode stalled from release, queue fills, then drains.
    pulseReset("t2");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "t2_fill");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "t2_fill");
    checkOutput("t2_full_count", 144'(q_count), 144'(2));
    checkOutput("t2_full_faddr", 144'(fetch_addr), 144'(72'h12));
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "t2_hold");
    checkOutput("t2_hold_faddr", 144'(fetch_addr), 144'(72'h12));
    checkOutput("t2_head0", 144'(dec_pc), 144'(expPc[0]));
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1, "t2_drain");
      checkOutput("t2_drain_pc", 144'(dec_pc), 144'(expPc[i]));
    end

    // Scenario 3: redirect while the queue is full.
    pulseReset("t3");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "t3_fill");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "t3_fill");
    applyStimulus(1'b1, 72'h90, 1'b0, 1'b0, "t3_redir");
    checkOutput("t3_redir_count", 144'(q_count), 144'(0));
    checkOutput("t3_redir_valid", 144'(dec_valid), 144'(0));
    checkOutput("t3_redir_faddr", 144'(fetch_addr), 144'(72'h90));
    applyStimulus(1'b0, '0, 1'b0, 1'b1, "t3_after");
    checkOutput("t3_pc90", 144'(dec_pc), 144'(72'h90));
    applyStimulus(1'b0, '0, 1'b0, 1'b1, "t3_after");
    checkOutput("t3_pc99", 144'(dec_pc), 144'(72'h99));

    // Scenario 4: PC wraps past the top of the address space.
    applyStimulus(1'b1, {{68{1'b1}}, 4'hC}, 1'b0, 1'b1, "t4_redir");
    applyStimulus(1'b0, '0, 1'b0, 1'b1, "t4_wrap");
    checkOutput("t4_wrap_faddr", 144'(fetch_addr), 144'(72'h5));

    // Scenario 5: halt with a full queue drains it and freezes the PC.
    applyStimulus(1'b1, 72'h200, 1'b0, 1'b0, "t5_redir");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "t5_fill");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "t5_fill");
    checkOutput("t5_full_count", 144'(q_count), 144'(2));
    held = fetch_addr;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b1, "t5_halt");
      checkOutput("t5_halt_faddr", 144'(fetch_addr), 144'(72'h212));
    end
    checkOutput("t5_drained", 144'(q_count), 144'(0));
    applyStimulus(1'b0, '0, 1'b0, 1'b1, "t5_resume");
    checkOutput("t5_resume_pc", 144'(dec_pc), 144'(held));

    // Scenario 6: asynchronous reset mid-stream, then random traffic.
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "t6_pre");
    pulseReset("t6");
    for (int i = 0; i < 400; i++) begin
      rnd = {$urandom(), $urandom(), $urandom()};
      applyStimulus($urandom_range(0, 15) == 0, rnd[71:0],
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                    "rand");
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
